// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types, default geometry and helpers for the icache refill sequencer.
// Consumers derive their own widths from these defaults or from overrides.
package icache_refill_ctrl_pkg;

  localparam int unsigned DEF_PLEN    = 56;
  localparam int unsigned DEF_LINE_W  = 128;
  localparam int unsigned DEF_BEAT_W  = 64;
  localparam int unsigned DEF_WAYS    = 4;
  localparam int unsigned DEF_INDEX_W = 12;

  function automatic int unsigned offset_w(
    input int unsigned line_w
  );
    return $clog2(line_w / 8);
  endfunction

  localparam int unsigned DEF_OFFSET_W = offset_w(DEF_LINE_W);
  localparam int unsigned DEF_SET_W    = DEF_INDEX_W - DEF_OFFSET_W;
  localparam int unsigned DEF_TAG_W    = DEF_PLEN - DEF_INDEX_W;
  localparam int unsigned DEF_BEATS    = DEF_LINE_W / DEF_BEAT_W;

  typedef enum logic [1:0] {
    REFILL_IDLE,
    REFILL_REQ,
    REFILL_RECV,
    REFILL_WRITE
  } refill_state_e;

  typedef struct packed {
    logic [DEF_WAYS-1:0]   way;
    logic [DEF_SET_W-1:0]  set;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_LINE_W-1:0] data;
  } icache_refill_wr_t;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Miss-side and memory-side handshakes of the icache refill sequencer.
// slave: the refill controller; master: lookup pipeline plus memory port.
interface icache_refill_ctrl_if #(
  parameter int unsigned PLEN   = 56,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned WAYS   = 4
);
  logic              miss_valid_i;
  logic              miss_ready_o;
  logic [PLEN-1:0]   miss_paddr_i;
  logic [WAYS-1:0]   way_valid_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [PLEN-1:0]   mem_req_addr_o;
  logic              mem_rsp_valid_i;
  logic [BEAT_W-1:0] mem_rsp_data_i;
  logic              mem_rsp_last_i;
  logic              mem_rsp_err_i;

  modport slave (
    input  miss_valid_i,
    output miss_ready_o,
    input  miss_paddr_i,
    input  way_valid_i,
    output mem_req_valid_o,
    input  mem_req_ready_i,
    output mem_req_addr_o,
    input  mem_rsp_valid_i,
    input  mem_rsp_data_i,
    input  mem_rsp_last_i,
    input  mem_rsp_err_i
  );

  modport master (
    output miss_valid_i,
    input  miss_ready_o,
    output miss_paddr_i,
    output way_valid_i,
    input  mem_req_valid_o,
    output mem_req_ready_i,
    input  mem_req_addr_o,
    output mem_rsp_valid_i,
    output mem_rsp_data_i,
    output mem_rsp_last_i,
    output mem_rsp_err_i
  );
endinterface

// File: rtl/icache_refill_ctrl_victim_sel.sv
// Victim way choice: first invalid way, else a round-robin pointer
// that moves only when the caller reports it was consumed.
module icache_victim_sel
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned WAYS = DEF_WAYS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [WAYS-1:0] valid_i,
  input  logic            advance_i,
  output logic [WAYS-1:0] way_o,
  output logic            rr_used_o
);
  localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(WAYS - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [WAYS-1:0]  free_way;
  logic             found;

  always_comb begin
    free_way = '0;
    found    = 1'b0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (!valid_i[i] && !found) begin
        free_way[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign rr_used_o = &valid_i;
  assign way_o     = rr_used_o ? (WAYS'(1) << ptr_q) : free_way;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Icache miss/refill sequencer: one line read per miss, beat assembly, array write.
// Define ICACHE_REFILL_PERF_EN to build the refill/stall performance counters.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned PLEN    = DEF_PLEN,
  parameter int unsigned LINE_W  = DEF_LINE_W,
  parameter int unsigned BEAT_W  = DEF_BEAT_W,
  parameter int unsigned WAYS    = DEF_WAYS,
  parameter int unsigned INDEX_W = DEF_INDEX_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  icache_refill_ctrl_if.slave       bus,
  output logic                      wr_en_o,
  output logic [WAYS-1:0]           wr_way_o,
  output logic [INDEX_W-offset_w(LINE_W)-1:0] wr_set_o,
  output logic [PLEN-INDEX_W-1:0]   wr_tag_o,
  output logic [LINE_W-1:0]         wr_data_o,
  output logic                      refill_done_o,
  output logic                      refill_err_o,
  output logic [31:0]               perf_miss_o,
  output logic [31:0]               perf_stall_o
);
  localparam int unsigned OFFSET_W = offset_w(LINE_W);
  localparam int unsigned SET_W    = INDEX_W - OFFSET_W;
  localparam int unsigned LA_W     = PLEN - OFFSET_W;
  localparam int unsigned BEATS    = LINE_W / BEAT_W;
  localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  refill_state_e     state_q, state_d;
  logic [LA_W-1:0]   la_q, la_d;
  logic [WAYS-1:0]   wv_q, wv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              kill_q, kill_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic              miss_ready;
  logic              req_valid;
  logic              done;
  logic              final_beat;
  logic [WAYS-1:0]   victim;
  logic              victim_rr;

  assign final_beat = (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REFILL_IDLE;
      la_q    <= '0;
      wv_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      wv_q    <= wv_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      kill_q  <= kill_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    la_d       = la_q;
    wv_d       = wv_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    kill_d     = kill_q;
    line_d     = line_q;
    miss_ready = 1'b0;
    req_valid  = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      REFILL_IDLE: begin
        miss_ready = ~flush_i;
        if (bus.miss_valid_i && !flush_i) begin
          la_d    = bus.miss_paddr_i[PLEN-1:OFFSET_W];
          wv_d    = bus.way_valid_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          kill_d  = 1'b0;
          state_d = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        req_valid = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (bus.mem_req_ready_i) state_d = REFILL_RECV;
      end
      REFILL_RECV: begin
        if (flush_i) kill_d = 1'b1;
        if (bus.mem_rsp_valid_i) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = bus.mem_rsp_data_i;
          cnt_d = cnt_q + 1'b1;
          // a misplaced last flag means the burst length disagrees with the line
          err_d = err_q | bus.mem_rsp_err_i
                | (bus.mem_rsp_last_i != final_beat);
          if (final_beat) state_d = REFILL_WRITE;
        end
      end
      REFILL_WRITE: begin
        done    = ~kill_q & ~flush_i;
        state_d = REFILL_IDLE;
      end
      default: state_d = REFILL_IDLE;
    endcase
  end

  icache_victim_sel #(
    .WAYS (WAYS)
  ) u_victim (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (wv_q),
    .advance_i (wr_en_o & victim_rr),
    .way_o     (victim),
    .rr_used_o (victim_rr)
  );

  assign bus.miss_ready_o    = miss_ready;
  assign bus.mem_req_valid_o = req_valid;
  assign bus.mem_req_addr_o  = {la_q, {OFFSET_W{1'b0}}};

  assign refill_done_o = done;
  assign refill_err_o  = done & err_q;
  assign wr_en_o       = done & ~err_q;
  assign wr_way_o      = wr_en_o ? victim : '0;
  assign wr_set_o      = wr_en_o ? la_q[SET_W-1:0] : '0;
  assign wr_tag_o      = wr_en_o ? la_q[LA_W-1:SET_W] : '0;
  assign wr_data_o     = wr_en_o ? line_q : '0;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] perf_miss_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_miss_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (refill_done_o && !refill_err_o && perf_miss_q != '1)
        perf_miss_q <= perf_miss_q + 1'b1;
      if (state_q != REFILL_IDLE && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_miss_o  = perf_miss_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_miss_o  = '0;
  assign perf_stall_o = '0;
`endif

`ifndef SYNTHESIS
  a_way_onehot: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    wr_en_o |-> $onehot(wr_way_o));

  a_req_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (req_valid && !bus.mem_req_ready_i)
    |=> (req_valid && $stable(bus.mem_req_addr_o)));

  a_rsp_in_recv: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.mem_rsp_valid_i |-> (state_q == REFILL_RECV));

  a_beats: assert property (
    @(posedge clk_i)
    (BEATS >= 1) && (BEATS * BEAT_W == LINE_W));
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomised scoreboard bench for icache_refill_ctrl.
// Driver pushes expected writes; a negedge monitor pops and compares.
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush = 1'b0;

  logic         wr_en_o;
  logic [3:0]   wr_way_o;
  logic [7:0]   wr_set_o;
  logic [43:0]  wr_tag_o;
  logic [127:0] wr_data_o;
  logic         refill_done_o;
  logic         refill_err_o;
  logic [31:0]  perf_miss_o;
  logic [31:0]  perf_stall_o;

  always #5 clk = ~clk;

  icache_refill_ctrl_if #(
    .PLEN(DEF_PLEN), .BEAT_W(DEF_BEAT_W), .WAYS(DEF_WAYS)
  ) bus ();

  icache_refill_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush),
    .bus           (bus),
    .wr_en_o       (wr_en_o),
    .wr_way_o      (wr_way_o),
    .wr_set_o      (wr_set_o),
    .wr_tag_o      (wr_tag_o),
    .wr_data_o     (wr_data_o),
    .refill_done_o (refill_done_o),
    .refill_err_o  (refill_err_o),
    .perf_miss_o   (perf_miss_o),
    .perf_stall_o  (perf_stall_o)
  );

  typedef struct {
    bit                err;
    icache_refill_wr_t wr;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   vecs = 0;
  int   miss = 0;
  int   rr = 0;
  int   exp_pmiss = 0;
  int   exp_pstall = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] pick_way(input logic [3:0] wv, input int ptr);
    logic [3:0] w;
    w = 4'b0001 << ptr;
    for (int i = 3; i >= 0; i--)
      if (!wv[i]) w = 4'b0001 << i;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // fmode: 0 none, 1 flush in REQ, 2 flush in RECV after beat 0, 3 flush in WRITE
  task automatic run_miss(input logic [55:0] pa, input logic [3:0] wv,
                          input int rdy_dly, input int err_beat,
                          input bit bad_last, input int fmode,
                          input logic [63:0] d0, input logic [63:0] d1);
    int n;
    int gap;
    bit killed;
    bit err;
    exp_t e;
    logic [63:0] bd [2];
    bd[0] = d0;
    bd[1] = d1;
    n = 0;
    while (bus.miss_ready_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("ready_timeout", bus.miss_ready_o, 1);
    bus.miss_valid_i = 1'b1;
    bus.miss_paddr_i = pa;
    bus.way_valid_i  = wv;
    @(negedge clk);
    chk("miss_ready", bus.miss_ready_o, 1);
    step();
    bus.miss_valid_i = 1'b0;
    bus.miss_paddr_i = {24'($urandom), $urandom};
    bus.way_valid_i  = ~wv;
    if (fmode == 1) flush = 1'b1;
    for (int d = 0; d <= rdy_dly; d++) begin
      if (d == rdy_dly) bus.mem_req_ready_i = 1'b1;
      @(negedge clk);
      chk("req_valid", bus.mem_req_valid_o, 1);
      chk("req_addr", bus.mem_req_addr_o, {pa[55:4], 4'h0});
      step();
      flush = 1'b0;
      bus.mem_req_ready_i = 1'b0;
      exp_pstall++;
    end
    for (int b = 0; b < 2; b++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        step();
        exp_pstall++;
      end
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = bd[b];
      bus.mem_rsp_last_i  = (b == 1) || (bad_last && b == 0);
      bus.mem_rsp_err_i   = (b == err_beat);
      if (fmode == 2 && b == 1) flush = 1'b1;
      if (b == 0) begin
        @(negedge clk);
        chk("req_drop", bus.mem_req_valid_o, 0);
      end
      step();
      exp_pstall++;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_last_i  = 1'b0;
      bus.mem_rsp_err_i   = 1'b0;
      flush = 1'b0;
    end
    killed = (fmode != 0);
    err = (err_beat >= 0) || bad_last;
    if (!killed) begin
      e.err     = err;
      e.wr.way  = pick_way(wv, rr);
      e.wr.set  = pa[11:4];
      e.wr.tag  = pa[55:12];
      e.wr.data = {bd[1], bd[0]};
      sbq.push_back(e);
      if (!err) begin
        exp_pmiss++;
        if (wv == 4'hF) rr = (rr + 1) % 4;
      end
    end
    if (fmode == 3) flush = 1'b1;
    @(negedge clk);
    chk("done_latency", refill_done_o, !killed);
    step();
    exp_pstall++;
    flush = 1'b0;
    @(negedge clk);
    chk("ready_back", bus.miss_ready_o, 1);
    step();
  endtask

  always @(negedge clk) begin
    if (rst_ni && (refill_done_o || wr_en_o)) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", {refill_done_o, wr_en_o}, 0);
      end else begin
        me = sbq.pop_front();
        chk("done", refill_done_o, 1);
        chk("err", refill_err_o, me.err);
        chk("wr_en", wr_en_o, !me.err);
        if (!me.err) begin
          chk("wr_way", wr_way_o, me.wr.way);
          chk("wr_set", wr_set_o, me.wr.set);
          chk("wr_tag", wr_tag_o, me.wr.tag);
          chk("wr_data", wr_data_o, me.wr.data);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miss_ready"}, bus.miss_ready_o, 1);
    chk({tag, "_req_valid"}, bus.mem_req_valid_o, 0);
    chk({tag, "_req_addr"}, bus.mem_req_addr_o, 0);
    chk({tag, "_wr_en"}, wr_en_o, 0);
    chk({tag, "_wr_way"}, wr_way_o, 0);
    chk({tag, "_done"}, refill_done_o, 0);
    chk({tag, "_err"}, refill_err_o, 0);
    chk({tag, "_perf_miss"}, perf_miss_o, 0);
    chk({tag, "_perf_stall"}, perf_stall_o, 0);
  endtask

  logic [55:0] rpa;
  logic [3:0]  rwv;
  int          rsel;
  int          rfm;
  int          reb;

  initial begin
    bus.miss_valid_i    = 1'b0;
    bus.miss_paddr_i    = '0;
    bus.way_valid_i     = '0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    bus.mem_rsp_last_i  = 1'b0;
    bus.mem_rsp_err_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");
    step();

    run_miss(56'h8000_1234, 4'b0000, 0, -1, 0, 0,
             64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB);
    run_miss(56'h0040_5670, 4'b1011, 1, -1, 0, 0,
             64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    for (int k = 0; k < 5; k++)
      run_miss({24'($urandom), $urandom}, 4'hF, k, -1, 0, 0,
               {$urandom, $urandom}, {$urandom, $urandom});
    run_miss(56'h0000_9AB0, 4'hF, 0, 0, 0, 0, 64'h1, 64'h2);
    run_miss(56'h0000_9AC0, 4'hF, 0, -1, 0, 0, 64'h3, 64'h4);
    run_miss(56'h0000_1000, 4'hF, 0, -1, 0, 2, 64'h5, 64'h6);
    run_miss(56'h00AB_CDE0, 4'h7, 10, -1, 0, 0, 64'h7, 64'h8);
    run_miss(56'h0000_2220, 4'hF, 2, -1, 1, 0, 64'h9, 64'hA);
    run_miss(56'h0000_3330, 4'hF, 2, -1, 0, 1, 64'hB, 64'hC);
    run_miss(56'h0000_4440, 4'hF, 0, -1, 0, 3, 64'hD, 64'hE);
    run_miss(56'h0000_5550, 4'hF, 0, 1, 0, 0, 64'hF, 64'h10);

    bus.miss_valid_i = 1'b1;
    bus.miss_paddr_i = 56'h0000_7770;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", bus.miss_ready_o, 0);
    step();
    bus.miss_valid_i = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", bus.mem_req_valid_o, 0);
    step();

    for (int k = 0; k < 40; k++) begin
      rpa  = {24'($urandom), $urandom};
      rwv  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      rsel = $urandom_range(0, 9);
      rfm  = (rsel == 0) ? $urandom_range(1, 3) : 0;
      reb  = (rsel == 1) ? $urandom_range(0, 1) : -1;
      run_miss(rpa, rwv, $urandom_range(0, 4), reb, rsel == 2, rfm,
               {$urandom, $urandom}, {$urandom, $urandom});
    end

`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_miss", perf_miss_o, exp_pmiss);
    chk("perf_stall", perf_stall_o, exp_pstall);
`else
    chk("perf_miss_off", perf_miss_o, 0);
    chk("perf_stall_off", perf_stall_o, 0);
`endif

    bus.miss_valid_i = 1'b1;
    bus.miss_paddr_i = 56'h0000_8880;
    bus.way_valid_i  = 4'hF;
    step();
    bus.miss_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 64'h1234;
    step();
    bus.mem_rsp_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    rr = 0;
    exp_pmiss = 0;
    exp_pstall = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    run_miss(56'h0000_9990, 4'hF, 0, -1, 0, 0, 64'h21, 64'h22);
    run_miss(56'h0000_AAA0, 4'hF, 0, -1, 0, 0, 64'h23, 64'h24);

`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_miss_after_rst", perf_miss_o, exp_pmiss);
`endif
    repeat (2) step();
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
